// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory program loader: FSM state
// encoding, word geometry and header width.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR0 = 3'd1,
    HDR1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_W          = 16;

endpackage

// File: rtl/loader_word_assembler.sv
// Collects little-endian bytes into 32-bit words; word_ready pulses (combinationally)
// with the 4th byte, while word carries the complete assembled value.
module loader_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0]  byte_cnt_q;
  logic [23:0] low_q;

  // The top byte is never stored: it completes the word in the same cycle.
  assign word_ready = byte_en && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word       = {byte_data, low_q};

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    if (!reset || clear) begin
      byte_cnt_q <= '0;
      low_q      <= '0;
    end else if (byte_en) begin
      case (byte_cnt_q)
        2'd0:    low_q[7:0]   <= byte_data;
        2'd1:    low_q[15:8]  <= byte_data;
        2'd2:    low_q[23:16] <= byte_data;
        default: ;
      endcase
      byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing instruction memory and gating CPU reset.
// Optional trailer checksum enabled by defining LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_run,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [HDR_W-1:0] DEPTH_N = HDR_W'(DEPTH);

  state_e            state_q, state_d;
  logic [HDR_W-1:0]  n_q;
  logic [HDR_W-1:0]  n_hdr;
  logic [ADDR_W-1:0] word_cnt_q;
  logic              xfer;
  logic              start_load;
  logic              word_ready;
  logic              last_word;
  logic [31:0]       word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign xfer       = s_valid && s_ready;
  assign n_hdr      = {s_data, n_q[7:0]};
  assign last_word  = word_ready && ((HDR_W'(word_cnt_q) + HDR_W'(1)) == n_q);
  assign start_load = (state_d == HDR0) && (state_q != HDR0);
  assign done       = (state_q == DONE);
  assign error      = (state_q == ERR);

  loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .clear      (start_load),
    .byte_en    ((state_q == DATA) && xfer),
    .byte_data  (s_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    s_ready = 1'b0;
    busy    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = HDR0;
      HDR0: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) state_d = HDR1;
      end
      HDR1: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
          if (n_hdr == '0)          state_d = CSUM;
`else
          if (n_hdr == '0)          state_d = DONE;
`endif
          else if (n_hdr > DEPTH_N) state_d = ERR;
          else                      state_d = DATA;
        end
      end
      DATA: begin
        s_ready = 1'b1;
        busy    = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        if (last_word) state_d = CSUM;
`else
        if (last_word) state_d = DONE;
`endif
      end
`ifdef LOADER_CHECKSUM_EN
      CSUM: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (xfer) state_d = (s_data == csum_q) ? DONE : ERR;
      end
`endif
      DONE, ERR: if (start) state_d = HDR0;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= IDLE;
      n_q        <= '0;
      word_cnt_q <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_run    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      // Rises one cycle after DONE is entered (after the last write) and
      // drops on the same edge that leaves DONE.
      cpu_run <= (state_q == DONE) && (state_d == DONE);
      imem_we <= word_ready;
      if (start_load) begin
        n_q        <= '0;
        word_cnt_q <= '0;
`ifdef LOADER_CHECKSUM_EN
        csum_q     <= '0;
`endif
      end
      if ((state_q == HDR0) && xfer) n_q[7:0]  <= s_data;
      if ((state_q == HDR1) && xfer) n_q[15:8] <= s_data;
      if (word_ready) begin
        imem_addr  <= word_cnt_q;
        imem_wdata <= word;
        word_cnt_q <= word_cnt_q + ADDR_W'(1);
      end
`ifdef LOADER_CHECKSUM_EN
      if ((state_q == DATA) && xfer) csum_q <= csum_q ^ s_data;
`endif
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (default DEPTH=256, ADDR_W=8);
// covers the LOADER_CHECKSUM_EN build when that macro is defined.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_ready;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          n_wr = 0;
  int          dup = 0;
  int          last_we_cyc = -1;
  int          run_rise_cyc = -1;
  logic        we_prev = 1'b0;
  logic        run_prev = 1'b0;
  logic [7:0]  wr_addr [16];
  logic [31:0] wr_data [16];

  imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_run    (cpu_run),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  always #5 clock = ~clock;

  // Write/cpu_run logger, sampled mid-cycle.
  always @(negedge clock) begin
    cyc = cyc + 1;
    if (imem_we) begin
      if (n_wr < 16) begin
        wr_addr[n_wr] = imem_addr;
        wr_data[n_wr] = imem_wdata;
      end
      n_wr = n_wr + 1;
      last_we_cyc = cyc;
      if (we_prev) dup = dup + 1;
    end
    we_prev = imem_we;
    if (cpu_run && !run_prev) run_rise_cyc = cyc;
    run_prev = cpu_run;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    n_wr = 0;
    dup = 0;
    last_we_cyc = -1;
    run_rise_cyc = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Offer one byte, optionally after an idle gap; bounded wait on s_ready.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    repeat (gap) step();
    s_valid = 1'b1;
    s_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (s_ready) ok = 1'b1;
      step();
    end
    s_valid = 1'b0;
    if (!ok) check("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_cpu_run"}, cpu_run, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Three-word program: 0x00000513, 0x005000B3, 0x00000133.
  task automatic load_prog(input int gap);
    logic [7:0] bytes [12];
    bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00,
              8'h33, 8'h01, 8'h00, 8'h00};
    send_byte(8'h03, gap);
    send_byte(8'h00, gap);
    for (int i = 0; i < 12; i++) send_byte(bytes[i], gap);
`ifdef LOADER_CHECKSUM_EN
    send_byte(8'hC7, gap);
`else
    check("last_write_strobe", imem_we, 1);
    check("last_write_addr", imem_addr, 2);
    check("done_with_last_write", done, 1);
    check("cpu_run_not_yet", cpu_run, 0);
    step();
    check("cpu_run_next_cycle", cpu_run, 1);
    check("we_single_cycle", imem_we, 0);
`endif
    repeat (3) step();
  endtask

  task automatic check_prog(input string tag);
    check({tag, "_writes"}, n_wr, 3);
    check({tag, "_dup_we"}, dup, 0);
    check({tag, "_addr0"}, wr_addr[0], 0);
    check({tag, "_data0"}, wr_data[0], 32'h0000_0513);
    check({tag, "_addr1"}, wr_addr[1], 1);
    check({tag, "_data1"}, wr_data[1], 32'h0050_00B3);
    check({tag, "_addr2"}, wr_addr[2], 2);
    check({tag, "_data2"}, wr_data[2], 32'h0000_0133);
    check({tag, "_run_rise"}, run_rise_cyc, last_we_cyc + 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_cpu_run"}, cpu_run, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
  endtask

  initial begin
    repeat (3) step();
    check_idle_outputs("por");
    reset = 1'b1;
    step();

    // Back-to-back load.
    clear_log();
    pulse_start();
    check("hdr0_busy", busy, 1);
    check("hdr0_s_ready", s_ready, 1);
    load_prog(0);
    check_prog("b2b");

    // Restart from DONE re-enters reset, then a load with gaps.
    clear_log();
    pulse_start();
    check("restart_cpu_run", cpu_run, 0);
    check("restart_done", done, 0);
    check("restart_busy", busy, 1);
    load_prog(1);
    check_prog("gap");

    // N = 257 exceeds DEPTH.
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    check("ovf_error", error, 1);
    check("ovf_s_ready", s_ready, 0);
    check("ovf_busy", busy, 0);
    repeat (3) step();
    check("ovf_cpu_run", cpu_run, 0);
    check("ovf_writes", n_wr, 0);
    pulse_start();
    check("ovf_restart_busy", busy, 1);
    check("ovf_restart_error", error, 0);
    check("ovf_restart_s_ready", s_ready, 1);

    // N = 0 (continues from HDR0).
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    check("n0_csum_busy", busy, 1);
    send_byte(8'h00, 0);
`endif
    check("n0_done", done, 1);
    step();
    check("n0_cpu_run", cpu_run, 1);
    check("n0_writes", n_wr, 0);

`ifdef LOADER_CHECKSUM_EN
    // One word 0x00000513: XOR of data bytes is 0x16.
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h16, 0);
    check("csum_good_done", done, 1);
    check("csum_good_writes", n_wr, 1);
    clear_log();
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'h13, 0);
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h17, 0);
    check("csum_bad_error", error, 1);
    check("csum_bad_writes", n_wr, 1);
    check("csum_bad_addr", wr_addr[0], 0);
    check("csum_bad_data", wr_data[0], 32'h0000_0513);
    step();
    check("csum_bad_cpu_run", cpu_run, 0);
`endif

    // Reset mid-load at word 2 of a 5-word load.
    clear_log();
    pulse_start();
    send_byte(8'h05, 0);
    send_byte(8'h00, 0);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h21 + i), 0);
    reset = 1'b0;
    step();
    check_idle_outputs("midrst");
    step();
    step();
    reset = 1'b1;
    s_valid = 1'b1;
    s_data  = 8'h55;
    repeat (5) step();
    s_valid = 1'b0;
    check("midrst_writes", n_wr, 2);
    check("midrst_word1", wr_data[1], 32'h2827_2625);
    check("midrst_busy", busy, 0);
    check("midrst_cpu_run", cpu_run, 0);
    check("midrst_s_ready", s_ready, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Program loader on the write side of the instruction-memory interface; the fetch unit is the read side.
- Accepts a byte stream (valid/ready) carrying a header word count and little-endian 32-bit instruction words, and writes each word into instruction memory at consecutive word addresses.
- Holds the processor in reset during loading and releases it only after a successful load.

Parameters:
- DEPTH, 256, instruction memory size in 32-bit words.
- ADDR_W, 8, word-address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  one-cycle pulse that begins a load; sampled only in IDLE, DONE or ERR.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  byte-stream ready.
- imem_we  output  1  instruction-memory write strobe, one-cycle pulse.
- imem_addr  output  ADDR_W  word address for the write.
- imem_wdata  output  32  instruction word for the write.
- cpu_run  output  1  high means the processor may run; the processor reset is driven by ~cpu_run.
- busy  output  1  high while a load is in progress (HDR0..DATA, or CSUM when enabled).
- done  output  1  high in the DONE state.
- error  output  1  high in the ERR state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - State goes to IDLE.
  - All outputs are 0: s_ready, imem_we, imem_addr, imem_wdata, cpu_run, busy, done, error.
  - Byte counter, word counter, word count N and the assembly register are cleared.
  - Reset mid-load aborts the load; words already written stay in memory, but cpu_run stays 0.
- Handshake: a byte transfers on a clock edge where s_valid && s_ready. s_ready is 1 in HDR0, HDR1, DATA and CSUM; it is 0 in all other states.
- State machine:
  - IDLE --start--> HDR0.
  - HDR0: the transferred byte is N[7:0]; go to HDR1.
  - HDR1: the transferred byte is N[15:8].
    - If N==0, go to DONE.
    - If N>DEPTH, go to ERR.
    - Otherwise go to DATA.
  - DATA: bytes fill the assembly register little-endian; byte k of a word goes to bits [8k+7:8k].
  - On the 4th byte of a word, in the next cycle:
    - imem_we=1 for exactly one cycle.
    - imem_wdata = the assembled word.
    - imem_addr = the word index (0..N-1).
  - After the Nth word is accepted, go to DONE. With LOADER_CHECKSUM_EN defined, go to CSUM instead.
  - DONE: cpu_run=1, done=1; state holds.
  - ERR: error=1, cpu_run=0; state holds.
  - From DONE or ERR, start returns to HDR0. On that transition cpu_run, done and error clear in the same cycle, so the processor re-enters reset.
  - start in HDR0..CSUM is ignored.
- Timing:
  - Maximum throughput is 1 byte per cycle; gaps in s_valid are tolerated at any byte position.
  - The write for the last word happens on the cycle DONE is entered; cpu_run rises one cycle after that write.
- Boundaries:
  - N==DEPTH is legal; the last address is DEPTH-1.
  - N==DEPTH+1 goes to ERR with no writes.
  - The word counter never wraps within a valid load.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR of all DATA bytes is kept.
  - A CSUM state follows DATA and accepts one trailer byte.
  - If the trailer equals the XOR, go to DONE; otherwise go to ERR.
  - With N==0, the block expects a trailer of 0x00.
- Not defined:
  - No CSUM state and no XOR register.
  - DATA (or HDR1 with N==0) goes directly to DONE.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, HDR0, HDR1, DATA, CSUM, DONE, ERR; 3 bits);
  - BYTES_PER_WORD = 4;
  - the header width, 16.
- One sub-module: loader_word_assembler (byte-lane shift/assembly register plus a 2-bit byte counter, producing a word-ready pulse).
- The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Reset held low for 3 cycles during a load at word 2 -> all outputs 0, state IDLE, cpu_run 0, no further writes.
- start, then header 0x03 0x00, then bytes 13 05 00 00 / B3 00 50 00 / 33 01 00 00 -> writes 0x00000513@0, 0x005000B3@1, 0x00000133@2; each imem_we exactly 1 cycle; cpu_run=1 one cycle after the last write.
- Same load with s_valid toggled every other cycle -> identical writes and addresses, with no duplicate imem_we.
- Header 0x01 0x01 (N=257) with DEPTH=256 -> ERR, error=1, s_ready=0, zero writes; a later start re-enters HDR0.
- Header 0x00 0x00 -> DONE in the cycle after HDR1, zero writes, cpu_run=1 (feature off).
- LOADER_CHECKSUM_EN, one word 0x00000513:
  - trailer 0x16 -> DONE;
  - trailer 0x17 -> ERR, with the word already written at address 0.
